// File: rtl/xf100_gnrl_rr_arb_pkg.sv
// Shared defaults for the round-robin arbiter. Uncomment the define below
// (ahead of the other arbiter files) to enable XF100_ARB_LOCK_EN burst locking.
// `define XF100_ARB_LOCK_EN

package xf100_gnrl_rr_arb_pkg;

  localparam int XF100_ARB_N_DEF  = 4;
  localparam int XF100_ARB_DW_DEF = 32;
  localparam int XF100_ARB_IW_DEF = 2;

endpackage

// File: rtl/xf100_dfflr.sv
// General enable-load flop with asynchronous active-low reset to zero.

module xf100_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (lden) begin
      q_reg <= dnxt;
    end
  end

  assign qout = q_reg;

endmodule

// File: rtl/xf100_gnrl_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above the one-hot
// ptr position, wrapping, via a double-width masked priority search.

module xf100_gnrl_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dgnt;

  // Subtracting ptr clears the lowest set bit at or above ptr; the upper copy
  // supplies the wrap-around candidates.
  assign dreq = {req, req};
  assign dgnt = dreq & ~(dreq - {{N{1'b0}}, ptr});
  assign gnt  = dgnt[N-1:0] | dgnt[2*N-1:N];

endmodule

// File: rtl/xf100_gnrl_rr_arb.sv
// N-way round-robin arbiter with zero-latency valid/ready grant and grant hold
// while stalled. Optional burst locking under XF100_ARB_LOCK_EN.

module xf100_gnrl_rr_arb
  import xf100_gnrl_rr_arb_pkg::*;
#(
  parameter int N  = XF100_ARB_N_DEF,
  parameter int DW = XF100_ARB_DW_DEF,
  parameter int IW = XF100_ARB_IW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic [N*DW-1:0] i_dat,
`ifdef XF100_ARB_LOCK_EN
  input  logic [N-1:0]    i_lock,
`endif
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DW-1:0]   o_dat,
  output logic [IW-1:0]   o_id
);

  logic [N-1:0] ptr;
  logic [N-1:0] ptr_raw;
  logic [N-1:0] ptr_nxt;
  logic         ptr_ld;
  logic         busy;
  logic         busy_nxt;
  logic         busy_ld;
  logic [N-1:0] gnt_q;
  logic         gnt_q_ld;
  logic [N-1:0] pick_gnt;
  logic [N-1:0] gnt;
  logic [N-1:0] win;
  logic         hold_vld;
  logic         hs;
  logic         stall;
  logic         lock_hit;

  // ptr is stored with bit 0 inverted so the zero-reset flop yields one-hot 1.
  assign ptr = ptr_raw ^ {{(N-1){1'b0}}, 1'b1};

  xf100_gnrl_rr_pick #(.N(N)) u_pick (
    .req (i_valid),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  assign gnt      = busy ? gnt_q : pick_gnt;
  assign win      = gnt & i_valid;
  assign o_valid  = |win;
  assign i_ready  = gnt & {N{o_ready}};
  assign hs       = o_valid & o_ready;
  assign stall    = o_valid & ~o_ready;
  assign hold_vld = |(gnt_q & i_valid);

`ifdef XF100_ARB_LOCK_EN
  assign lock_hit = |(gnt & i_lock);
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    o_dat = '0;
    o_id  = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        o_dat = o_dat | i_dat[i*DW +: DW];
        o_id  = o_id | IW'(i);
      end
    end
  end

  always_comb begin
    busy_ld  = 1'b0;
    busy_nxt = busy;
    if (hs) begin
      busy_ld  = 1'b1;
      busy_nxt = lock_hit;
    end else if (stall) begin
      busy_ld  = 1'b1;
      busy_nxt = 1'b1;
    end else if (busy && !hold_vld) begin
      busy_ld  = 1'b1;
      busy_nxt = 1'b0;
    end
  end

  assign gnt_q_ld = stall | (hs & lock_hit);
  assign ptr_ld   = hs & ~lock_hit;
  assign ptr_nxt  = {gnt[N-2:0], gnt[N-1]};

  xf100_dfflr #(.DW(N)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (ptr_ld),
    .dnxt  (ptr_nxt ^ {{(N-1){1'b0}}, 1'b1}),
    .qout  (ptr_raw)
  );

  xf100_dfflr #(.DW(1)) u_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (busy_ld),
    .dnxt  (busy_nxt),
    .qout  (busy)
  );

  xf100_dfflr #(.DW(N)) u_gnt_q (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (gnt_q_ld),
    .dnxt  (gnt),
    .qout  (gnt_q)
  );

endmodule

// File: tb/tb_xf100_gnrl_rr_arb.sv
// Scoreboard bench for xf100_gnrl_rr_arb (N=4, DW=32); the lock sequence runs
// only when XF100_ARB_LOCK_EN is defined.

module tb_xf100_gnrl_rr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct {
    logic          v;
    logic [IW-1:0] id;
    logic [DW-1:0] dat;
    logic [N-1:0]  rdy;
    string         tag;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_lock;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_dat;
  logic [IW-1:0]   o_id;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;
  int   cyc;

  xf100_gnrl_rr_arb #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_dat   (i_dat),
`ifdef XF100_ARB_LOCK_EN
    .i_lock  (i_lock),
`endif
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_dat   (o_dat),
    .o_id    (o_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_dat();
    for (int k = 0; k < N; k++) begin
      i_dat[k*DW +: DW] = {4'(k), 28'(cyc)};
    end
  endtask

  task automatic push_exp(input string tag, input logic ev, input int eid);
    exp_t e;
    e.tag = tag;
    e.v   = ev;
    e.id  = ev ? IW'(eid) : '0;
    e.dat = ev ? {4'(eid), 28'(cyc)} : '0;
    e.rdy = (ev && o_ready) ? N'(1 << eid) : '0;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      $display("[%0t] %s: vld=%b rdy=%b lock=%b -> o_valid=%b o_id=%0d o_dat=%h i_ready=%b",
               $time, e.tag, i_valid, o_ready, i_lock, o_valid, o_id, o_dat, i_ready);
      chk({e.tag, ".o_valid"}, DW'(o_valid), DW'(e.v));
      chk({e.tag, ".o_id"},    DW'(o_id),    DW'(e.id));
      chk({e.tag, ".o_dat"},   o_dat,        e.dat);
      chk({e.tag, ".i_ready"}, DW'(i_ready), DW'(e.rdy));
    end
  endtask

  // Drive one cycle, predict, compare on the falling edge, advance past the next rise.
  task automatic step(input string tag, input logic [N-1:0] v, input logic r,
                      input logic ev, input int eid, input logic [N-1:0] lk);
    cyc++;
    i_valid = v;
    o_ready = r;
    i_lock  = lk;
    drive_dat();
    push_exp(tag, ev, eid);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    i_valid = '0;
    o_ready = 1'b0;
    i_lock  = '0;
    drive_dat();

    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 1'b0, 0);
    @(negedge clk);
    sb_check();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) step("rr_all", 4'b1111, 1'b1, 1'b1, i % 4, '0);

    for (int i = 0; i < 3; i++) step("stall2", 4'b0100, 1'b0, 1'b1, 2, '0);
    step("stall2_acc", 4'b0101, 1'b1, 1'b1, 2, '0);
    step("after2",     4'b0001, 1'b1, 1'b1, 0, '0);

    for (int i = 0; i < 5; i++) step("b2b1", 4'b0010, 1'b1, 1'b1, 1, '0);
    step("after1", 4'b0011, 1'b1, 1'b1, 0, '0);

    step("hold3",  4'b1000, 1'b0, 1'b1, 3, '0);
    step("drop3",  4'b0000, 1'b0, 1'b0, 0, '0);
    step("ptr_kept", 4'b1111, 1'b1, 1'b1, 1, '0);

    step("busy3", 4'b1000, 1'b0, 1'b1, 3, '0);
    cyc++;
    i_valid = 4'b1010;
    o_ready = 1'b0;
    rst_n   = 1'b0;
    drive_dat();
    #2;
    push_exp("async_rst", 1'b1, 1);
    sb_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 4'b1010, 1'b1, 1'b1, 1, '0);

`ifdef XF100_ARB_LOCK_EN
    for (int i = 0; i < 3; i++) step("lock2", 4'b1101, 1'b1, 1'b1, 2, 4'b0100);
    step("lock2_last", 4'b1101, 1'b1, 1'b1, 2, 4'b0000);
    step("unlock",     4'b1101, 1'b1, 1'b1, 3, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xf100_gnrl_rr_arb.md
Name: xf100_gnrl_rr_arb

Overview:
- N-way round-robin arbiter with valid/ready handshake.
- Shares one downstream port among N requesters, e.g. IFU/LSU into a shared memory port, or multiple writers into one register-file write port.
- Grant is combinational (zero latency). Priority pointer and grant-hold state are registered.
- Once a beat is presented downstream, its grant stays stable until that beat is accepted.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 32, payload width per requester.
- IW, 2, width of the winner index; must equal clog2(N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_valid  in  N  per-requester request valid.
- i_ready  out  N  per-requester accept: i_ready[k] = gnt[k] & o_ready.
- i_dat  in  N*DW  payloads, flattened; requester k occupies bits [k*DW +: DW].
- o_valid  out  1  downstream valid.
- o_ready  in  1  downstream ready.
- o_dat  out  DW  payload of the winner.
- o_id  out  IW  binary index of the winner.

Behaviour:
- State registers:
  - ptr: N-bit one-hot priority pointer; reset value 1 (requester 0 has highest priority).
  - busy: 1 bit; reset value 0.
  - gnt_q: N bits; reset value 0.
- Grant (combinational):
  - If busy: gnt = gnt_q.
  - Else: gnt = first set bit of i_valid, searching from ptr's position upward with wrap from N-1 to 0.
  - gnt is one-hot or all-zero.
- Outputs (combinational, no registered outputs):
  - o_valid = |(gnt & i_valid).
  - o_dat = i_dat slice of the winner, else 0.
  - o_id = index of the winner, else 0.
  - With i_valid = 0, all outputs are 0, including during reset.
- Handshake: hs = o_valid & o_ready; the transfer completes in the same cycle (zero latency).
- Next-state rules, in priority order:
  1. hs: ptr <= gnt rotated left by 1 (requester after the winner); busy <= 0.
  2. o_valid & ~o_ready: busy <= 1; gnt_q <= gnt. Grant is frozen; a higher-priority request arriving later cannot preempt it.
  3. busy & ~(|(gnt_q & i_valid)): busy <= 0. This recovers from a held requester dropping valid (a protocol violation). ptr is unchanged.
  4. Otherwise: hold all state.
- ptr never changes without a handshake, so idle cycles do not advance fairness.
- Requester protocol: hold valid and data stable until i_ready. Holding valid is not required once the arbiter has accepted the beat.
- Back-to-back operation:
  - A single requester held valid with o_ready = 1 is granted every cycle: one beat per cycle, no bubbles.
  - With all N requesting and o_ready = 1, grants rotate 0,1,..,N-1,0 with one grant per cycle.
- Asynchronous reset mid-transfer: busy clears, ptr returns to 1, and any frozen grant is abandoned immediately.
- N not a power of 2: ptr wraps from bit N-1 to bit 0. o_id is never >= N.

Optional Feature:
- Macro: XF100_ARB_LOCK_EN.
- Defined:
  - Adds input port i_lock (width N).
  - If hs occurs and i_lock[winner] = 1: busy <= 1, gnt_q <= gnt, ptr unchanged. The winner keeps the port for its next beat (multi-beat burst).
  - The lock releases on the first handshake with i_lock[winner] = 0; ptr then advances per rule 1.
  - Rule 3 also releases a lock if the winner drops valid.
- Undefined:
  - No i_lock port.
  - Every handshake re-arbitrates.

Decomposition:
- Shared defines header:
  - XF100_ARB_LOCK_EN macro (commented out by default).
  - Default values for N and DW.
- Sub-module xf100_gnrl_rr_pick: purely combinational.
  - Inputs: req[N], ptr[N]. Output: one-hot gnt[N].
  - Implemented as a double-width masked priority search.
  - Reused later by other schedulers.
- All state flops (ptr, busy, gnt_q) use the general enable-load reset flop, xf100_dfflr; no bespoke always blocks.
- ptr flop caveat: xf100_dfflr resets to 0, but ptr must reset to one-hot 1. Either add a set-reset variant of that flop, or store ptr inverted in bit 0 so the flop's zero reset yields ptr = 1.

Test Plan:
- Reset, then i_valid=4'b1111 held, o_ready=1 for 8 cycles -> o_id sequence 0,1,2,3,0,1,2,3; one hs per cycle.
- i_valid=4'b0100, o_ready=0 for 3 cycles, then i_valid=4'b0101 with o_ready=1 -> o_id stays 2 with o_dat constant while stalled; beat 2 accepted; next grant is 0.
- Only requester 1 valid for 5 cycles, o_ready=1 -> 5 back-to-back beats with o_id=1; then i_valid=4'b0011 -> next winner is 0.
- Held requester 3 drops valid while o_ready=0 -> busy clears the next cycle; o_valid=0; ptr unchanged.
- rst_n pulsed low while busy with gnt=4'b1000 -> asynchronous clear; after release, i_valid=4'b1010 grants 1.
- XF100_ARB_LOCK_EN defined: requester 2 issues 4 beats with i_lock[2]=1, i_lock[2]=0 on the 4th beat, while requesters 0 and 3 are valid -> 4 consecutive grants to 2, then grant 3.
